// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue front-end.
// Control codes, ALUOp/funct encodings and FSM states.
package alu_pkg;

  localparam logic [3:0] CTL_AND = 4'h0;
  localparam logic [3:0] CTL_OR  = 4'h1;
  localparam logic [3:0] CTL_ADD = 4'h2;
  localparam logic [3:0] CTL_SUB = 4'h6;
  localparam logic [3:0] CTL_SLT = 4'h7;
  localparam logic [3:0] CTL_NOR = 4'hC;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CAPT,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/alu_32.sv
// Registered 32-bit ALU driven by the issue front-end.
// Result and flags update one clock after operands.
module alu_32
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_s,
  input  logic [31:0] i_t,
  input  logic [3:0]  i_control,
  output logic [31:0] o_result,
  output logic        o_zero,
  output logic        o_cout
);

  logic [32:0] w_sum;
  logic [32:0] w_dif;
  logic [31:0] w_res;
  logic        w_cout;

  assign w_sum = {1'b0, i_s} + {1'b0, i_t};
  assign w_dif = {1'b0, i_s} + {1'b0, ~i_t} + 33'd1;

  // Select the function result and carry for this control code.
  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    case (i_control)
      CTL_AND: w_res = i_s & i_t;
      CTL_OR:  w_res = i_s | i_t;
      CTL_ADD: begin
        w_res  = w_sum[31:0];
        w_cout = w_sum[32];
      end
      CTL_SUB: begin
        w_res  = w_dif[31:0];
        w_cout = w_dif[32];
      end
      CTL_SLT: w_res = {31'd0, i_s < i_t};
      CTL_NOR: w_res = ~(i_s | i_t);
      default: w_res = '0;
    endcase
  end

  // Register result and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_result <= '0;
      o_zero   <= 1'b1;
      o_cout   <= 1'b0;
    end else begin
      o_result <= w_res;
      o_zero   <= (w_res == 32'd0);
      o_cout   <= w_cout;
    end
  end

endmodule

// File: rtl/alu_decode.sv
// ALUOp/funct to ALU control translation.
// Purely combinational; unknown R-type funct flags illegal.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [3:0] o_control,
  output logic       o_signed_arith,
  output logic       o_slt_signed,
  output logic       o_illegal
);

  // Map the operation class and funct to a control code.
  always_comb begin
    o_control      = CTL_AND;
    o_signed_arith = 1'b0;
    o_slt_signed   = 1'b0;
    o_illegal      = 1'b0;
    case (i_aluop)
      OP_ADD: o_control = CTL_ADD;
      OP_SUB: o_control = CTL_SUB;
      OP_OR:  o_control = CTL_OR;
      default: begin
        case (i_funct)
          FN_ADD: begin
            o_control      = CTL_ADD;
            o_signed_arith = 1'b1;
          end
          FN_ADDU: o_control = CTL_ADD;
          FN_SUB: begin
            o_control      = CTL_SUB;
            o_signed_arith = 1'b1;
          end
          FN_SUBU: o_control = CTL_SUB;
          FN_AND:  o_control = CTL_AND;
          FN_OR:   o_control = CTL_OR;
          FN_NOR:  o_control = CTL_NOR;
          FN_SLT: begin
            o_control    = CTL_SLT;
            o_slt_signed = 1'b1;
          end
          FN_SLTU: o_control = CTL_SLT;
          default: o_illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture sequencer around the registered ALU.
// Four-state FSM: accept, ALU latch, capture, hold.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_aluop,
  input  logic [5:0]  in_funct,
  input  logic        in_bne,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_s,
  output logic [31:0] alu_t,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_ovf_trap,
  output logic        out_branch_taken,
  output logic        out_illegal
);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  w_ctl;
  logic        w_sarith;
  logic        w_sltsg;
  logic        w_illegal;
  logic        w_accept;
  logic [31:0] w_s;
  logic [31:0] w_t;
  logic        w_ovf;
  logic        w_unused;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_trap_add;
  logic        r_trap_sub;
  logic        r_branch;
  logic        r_bne;
  logic        r_illegal;

  assign w_unused = alu_cout;

  alu_decode u_dec (
    .i_aluop       (in_aluop),
    .i_funct       (in_funct),
    .o_control     (w_ctl),
    .o_signed_arith(w_sarith),
    .o_slt_signed  (w_sltsg),
    .o_illegal     (w_illegal)
  );

  assign in_ready = (r_state == ST_IDLE);
  assign w_accept = in_valid && (r_state == ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state sequencing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_CAPT;
      ST_CAPT: w_next = ST_HOLD;
      ST_HOLD: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand shaping: zero for illegal, sign-bias for signed slt.
  always_comb begin
    w_s = in_a;
    w_t = in_b;
    if (w_illegal) begin
      w_s = '0;
      w_t = '0;
    end else if (w_sltsg) begin
      w_s = {~in_a[31], in_a[30:0]};
      w_t = {~in_b[31], in_b[30:0]};
    end
  end

  // Signed overflow from the unbiased operands and ALU result.
  always_comb begin
    w_ovf = 1'b0;
    if (r_trap_add)
      w_ovf = (r_a[31] == r_b[31]) && (alu_result[31] != r_a[31]);
    else if (r_trap_sub)
      w_ovf = (r_a[31] != r_b[31]) && (alu_result[31] != r_a[31]);
  end

  // Latch the accepted operation and drive the ALU inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_s       <= '0;
      alu_t       <= '0;
      alu_control <= CTL_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_trap_add  <= 1'b0;
      r_trap_sub  <= 1'b0;
      r_branch    <= 1'b0;
      r_bne       <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      alu_s       <= w_s;
      alu_t       <= w_t;
      alu_control <= w_ctl;
      r_a         <= in_a;
      r_b         <= in_b;
      r_trap_add  <= w_sarith && (w_ctl == CTL_ADD);
      r_trap_sub  <= w_sarith && (w_ctl == CTL_SUB);
      r_branch    <= (in_aluop == OP_SUB);
      r_bne       <= in_bne;
      r_illegal   <= w_illegal;
    end
  end

  // Capture the ALU result and flags; release on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid        <= 1'b0;
      out_result       <= '0;
      out_ovf_trap     <= 1'b0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else if (r_state == ST_CAPT) begin
      out_valid        <= 1'b1;
      out_result       <= r_illegal ? 32'd0 : alu_result;
      out_ovf_trap     <= w_ovf && !r_illegal;
      out_branch_taken <= r_branch && (alu_zero ^ r_bne);
      out_illegal      <= r_illegal;
    end else if (r_state == ST_HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with the registered ALU.
// Each scenario task checks its own expected values inline.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [5:0]  in_funct;
  logic        in_bne;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] alu_s;
  logic [31:0] alu_t;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf_trap;
  logic        out_branch_taken;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_aluop        (in_aluop),
    .in_funct        (in_funct),
    .in_bne          (in_bne),
    .in_a            (in_a),
    .in_b            (in_b),
    .alu_s           (alu_s),
    .alu_t           (alu_t),
    .alu_control     (alu_control),
    .alu_result      (alu_result),
    .alu_zero        (alu_zero),
    .alu_cout        (alu_cout),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_ovf_trap    (out_ovf_trap),
    .out_branch_taken(out_branch_taken),
    .out_illegal     (out_illegal)
  );

  alu_32 u_alu (
    .clk      (clk),
    .reset    (reset),
    .i_s      (alu_s),
    .i_t      (alu_t),
    .i_control(alu_control),
    .o_result (alu_result),
    .o_zero   (alu_zero),
    .o_cout   (alu_cout)
  );

  task automatic drive_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic bne, input logic [31:0] a,
                          input logic [31:0] b);
    @(negedge clk);
    in_aluop = op;
    in_funct = fn;
    in_bne   = bne;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_out got v=%b r=%h want v=0 r=0", out_valid, out_result);
    end
    n_checks++;
    if ({out_ovf_trap, out_branch_taken, out_illegal} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000",
               {out_ovf_trap, out_branch_taken, out_illegal});
    end
    n_checks++;
    if (alu_s !== 32'd0 || alu_t !== 32'd0 || alu_control !== 4'h2) begin
      n_fail++;
      $display("FAIL reset_alu_in got s=%h t=%h c=%h want 0 0 2",
               alu_s, alu_t, alu_control);
    end
  endtask

  task automatic test_add_ovf();
    int lat;
    drive_op(2'b10, 6'h20, 1'b0, 32'h7FFF_FFFF, 32'h1);
    wait_out(lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL add_latency got %0d want 3", lat);
    end
    n_checks++;
    if (out_result !== 32'h8000_0000 || out_ovf_trap !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ovf got r=%h t=%b want 80000000 1", out_result, out_ovf_trap);
    end
    release_out();
    drive_op(2'b10, 6'h21, 1'b0, 32'h7FFF_FFFF, 32'h1);
    wait_out(lat);
    n_checks++;
    if (out_result !== 32'h8000_0000 || out_ovf_trap !== 1'b0) begin
      n_fail++;
      $display("FAIL addu_noovf got r=%h t=%b want 80000000 0", out_result, out_ovf_trap);
    end
    release_out();
    drive_op(2'b10, 6'h22, 1'b0, 32'h8000_0000, 32'h1);
    wait_out(lat);
    n_checks++;
    if (out_result !== 32'h7FFF_FFFF || out_ovf_trap !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_ovf got r=%h t=%b want 7fffffff 1", out_result, out_ovf_trap);
    end
    release_out();
    drive_op(2'b10, 6'h22, 1'b0, 32'h5, 32'h7);
    wait_out(lat);
    n_checks++;
    if (out_result !== 32'hFFFF_FFFE || out_ovf_trap !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_plain got r=%h t=%b want fffffffe 0", out_result, out_ovf_trap);
    end
    release_out();
  endtask

  task automatic test_slt();
    int lat;
    drive_op(2'b10, 6'h2A, 1'b0, 32'hFFFF_FFFF, 32'h1);
    wait_out(lat);
    n_checks++;
    if (out_result !== 32'd1) begin
      n_fail++; $display("FAIL slt_result got %h want 1", out_result);
    end
    n_checks++;
    if (alu_s !== 32'h7FFF_FFFF || alu_t !== 32'h8000_0001 || alu_control !== 4'h7) begin
      n_fail++;
      $display("FAIL slt_bias got s=%h t=%h c=%h want 7fffffff 80000001 7",
               alu_s, alu_t, alu_control);
    end
    release_out();
    drive_op(2'b10, 6'h2B, 1'b0, 32'hFFFF_FFFF, 32'h1);
    wait_out(lat);
    n_checks++;
    if (out_result !== 32'd0 || alu_s !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL sltu_result got r=%h s=%h want 0 ffffffff", out_result, alu_s);
    end
    release_out();
  endtask

  task automatic test_branch();
    int lat;
    drive_op(2'b01, 6'h00, 1'b0, 32'h1234, 32'h1234);
    wait_out(lat);
    n_checks++;
    if (out_branch_taken !== 1'b1 || out_result !== 32'd0) begin
      n_fail++;
      $display("FAIL beq_eq got tk=%b r=%h want 1 0", out_branch_taken, out_result);
    end
    release_out();
    drive_op(2'b01, 6'h00, 1'b1, 32'h1234, 32'h1234);
    wait_out(lat);
    n_checks++;
    if (out_branch_taken !== 1'b0) begin
      n_fail++; $display("FAIL bne_eq got %b want 0", out_branch_taken);
    end
    release_out();
    drive_op(2'b01, 6'h00, 1'b0, 32'h5, 32'h6);
    wait_out(lat);
    n_checks++;
    if (out_branch_taken !== 1'b0 || out_result !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL beq_ne got tk=%b r=%h want 0 ffffffff", out_branch_taken, out_result);
    end
    release_out();
    drive_op(2'b01, 6'h00, 1'b1, 32'h5, 32'h6);
    wait_out(lat);
    n_checks++;
    if (out_branch_taken !== 1'b1) begin
      n_fail++; $display("FAIL bne_ne got %b want 1", out_branch_taken);
    end
    release_out();
  endtask

  task automatic test_logic();
    logic [1:0]  ops [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
    logic [5:0]  fns [5] = '{6'h24, 6'h25, 6'h27, 6'h3F, 6'h23};
    logic [31:0] as  [5] = '{32'hF0F0_00FF, 32'hF000_0000, 32'h0F0F_0000,
                             32'h0000_0010, 32'h0000_0003};
    logic [31:0] bs  [5] = '{32'h0FF0_0F0F, 32'h0000_000F, 32'h0000_F0F0,
                             32'hFFFF_FFFC, 32'h0000_0005};
    logic [31:0] exp [5] = '{32'h00F0_000F, 32'hF000_000F, 32'hF0F0_0F0F,
                             32'h0000_000C, 32'hFFFF_FFFE};
    int lat;
    for (int i = 0; i < 5; i++) begin
      drive_op(ops[i], fns[i], 1'b0, as[i], bs[i]);
      wait_out(lat);
      n_checks++;
      if (out_result !== exp[i] || out_illegal !== 1'b0 || out_ovf_trap !== 1'b0) begin
        n_fail++;
        $display("FAIL logic_%0d got r=%h il=%b ov=%b want %h 0 0",
                 i, out_result, out_illegal, out_ovf_trap, exp[i]);
      end
      release_out();
    end
  endtask

  task automatic test_illegal();
    int lat;
    drive_op(2'b10, 6'h3F, 1'b0, 32'h1234, 32'h5678);
    wait_out(lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL illegal_latency got %0d want 3", lat);
    end
    n_checks++;
    if (out_illegal !== 1'b1 || out_result !== 32'd0 ||
        out_ovf_trap !== 1'b0 || out_branch_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_out got il=%b r=%h ov=%b tk=%b want 1 0 0 0",
               out_illegal, out_result, out_ovf_trap, out_branch_taken);
    end
    n_checks++;
    if (alu_control !== 4'h0 || alu_s !== 32'd0 || alu_t !== 32'd0) begin
      n_fail++;
      $display("FAIL illegal_alu got c=%h s=%h t=%h want 0 0 0",
               alu_control, alu_s, alu_t);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    drive_op(2'b10, 6'h21, 1'b0, 32'h0000_0100, 32'h0000_0023);
    wait_out(lat);
    in_aluop = 2'b11;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_result !== 32'h0000_0123 ||
          in_ready !== 1'b0 || alu_s !== 32'h0000_0100) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold_frozen got %0d bad cycles want 0 (r=%h rdy=%b)",
               bad, out_result, in_ready);
    end
    release_out();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int ready_at = 0;
    int vcount   = 0;
    out_ready = 1'b1;
    drive_op(2'b00, 6'h00, 1'b0, 32'h10, 32'h20);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
      if (in_ready && ready_at == 0) ready_at = i;
    end
    out_ready = 1'b0;
    n_checks++;
    if (ready_at !== 4 || vcount !== 1) begin
      n_fail++;
      $display("FAIL b2b_interval got ready_at=%0d vcycles=%0d want 4 1",
               ready_at, vcount);
    end
    n_checks++;
    if (out_result !== 32'h30) begin
      n_fail++; $display("FAIL b2b_result got %h want 30", out_result);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    drive_op(2'b10, 6'h20, 1'b0, 32'h7FFF_FFFF, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_control !== 4'h2) begin
      n_fail++;
      $display("FAIL midreset got v=%b rdy=%b c=%h want 0 1 2",
               out_valid, in_ready, alu_control);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_ovf_trap !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_drop got v=%b ov=%b want 0 0", out_valid, out_ovf_trap);
    end
    drive_op(2'b11, 6'h00, 1'b0, 32'hF0, 32'h0F);
    wait_out(lat);
    n_checks++;
    if (lat !== 3 || out_result !== 32'hFF) begin
      n_fail++;
      $display("FAIL ori_after_reset got lat=%0d r=%h want 3 ff", lat, out_result);
    end
    release_out();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_aluop  = 2'b00;
    in_funct  = 6'h00;
    in_bne    = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    test_reset();
    test_add_ovf();
    test_slt();
    test_branch();
    test_logic();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing front-end for the registered 32-bit ALU (`alu_32`). It accepts one decoded operation per handshake, translates MIPS ALUOp/funct into the ALU's 4-bit control code, and drives the ALU's operand and control inputs. It then captures the ALU result one clock later and returns the result with signed-overflow trap, branch-taken and illegal flags. It sits between decode/register-read and writeback/branch logic in the multicycle datapath.

## Interface
Parameters:
- none (control codes are constants from the shared package)

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  reset, synchronous, active-high; also drives the ALU's reset
- in_valid  in  1  operation offered
- in_ready  out  1  high only in IDLE
- in_aluop  in  2  00=ADD (lw/sw), 01=SUB branch compare, 10=R-type by funct, 11=OR (ori)
- in_funct  in  6  R-type funct; used only when in_aluop=10
- in_bne  in  1  for aluop 01: 0=beq, 1=bne
- in_a, in_b  in  32  rs operand, rt/immediate operand
- alu_s, alu_t  out  32  registered ALU operands
- alu_control  out  4  registered ALU control code
- alu_result  in  32  ALU registered result
- alu_zero, alu_cout  in  1  ALU flags (alu_cout unused except for debug)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_result  out  32  captured result
- out_ovf_trap, out_branch_taken, out_illegal  out  1  status flags, valid with out_valid

## Operation
- Decode: aluop 00→ADD(2); 01→SUB(6); 11→OR(1); 10: funct 0x20 add, 0x21 addu→ADD; 0x22 sub, 0x23 subu→SUB; 0x24→AND(0); 0x25→OR; 0x27→NOR(C); 0x2A slt, 0x2B sltu→SLT(7).
- Any other funct under aluop 10 is illegal. In that case alu_control=AND, operands are zero, out_result=0, out_illegal=1, other flags 0. Latency is unchanged.
- The ALU SLT compares unsigned. For slt (0x2A) the block inverts bit 31 of both operands before issue, which makes the unsigned compare equal the signed compare. sltu passes operands unmodified.
- Overflow trap: only for funct 0x20 and 0x22, computed from the latched operands (pre-bias) and alu_result.
  - add: a[31]==b[31] && r[31]!=a[31].
  - sub: a[31]!=b[31] && r[31]!=a[31].
  - When the trap fires, out_result still carries the wrapped result.
- Branch: out_branch_taken = alu_zero XOR in_bne (latched) for aluop 01. It is 0 for all other ops.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch fields, register alu_s/alu_t/alu_control, go to EXEC.
  - EXEC: the ALU latches at this edge. Go to CAPT.
  - CAPT: capture alu_result and compute flags into the out_* registers. Set out_valid=1 and go to HOLD.
  - HOLD: hold outputs stable. On out_ready, clear out_valid and go to IDLE.

## Timing
- Accept at edge E0. out_valid rises after E2 (3-cycle latency). Minimum issue interval is 4 cycles when out_ready is held high.
- in_ready is a decode of state only. There are no combinational in→out paths.
- alu_s/t/control hold their values from E0 until the next accept.
- out_result and out flags are stable from CAPT exit until the HOLD handshake.
- Reset (any state, including mid-EXEC/HOLD), at the next edge:
  - state=IDLE
  - in_ready=1 (after reset deasserts)
  - out_valid=0, out_result=0, all flags 0
  - alu_s=alu_t=0, alu_control=ADD
  - An in-flight operation is dropped.
- in_valid while not IDLE is ignored. The source must hold it until accepted.
- Back-pressure: out_ready low in HOLD stalls indefinitely with outputs frozen.

## Structure
- Shared package `alu_pkg`:
  - ALU control constants (AND/OR/ADD/SUB/SLT/NOR)
  - ALUOp codes
  - funct constants
  - FSM state enum
- One natural sub-module: `alu_decode`, a combinational aluop/funct→{control, is_signed_arith, is_slt_signed, illegal}.
- Testbench instantiates alu_issue_ctrl with alu_32.

## Test plan
- R-add 0x7FFFFFFF+1 (funct 0x20) → out_result=0x80000000, out_ovf_trap=1, out_valid 3 cycles after accept. The same operands with addu (0x21) give trap=0.
- slt a=0xFFFFFFFF (−1), b=1 → result=1. sltu with the same operands → result=0.
- beq a=b=0x1234 → taken=1. bne with the same operands → taken=0. beq with a=5, b=6 → taken=0.
- funct 0x3F under aluop 10 → out_illegal=1, out_result=0, latency 3.
- out_ready held low 10 cycles in HOLD → outputs frozen and in_ready=0. On release, IDLE is reached the next cycle.
- reset asserted during EXEC → next cycle out_valid=0 and in_ready=1. A subsequent ori 0xF0|0x0F → 0xFF.
